// File: rtl/word_collector_pkg.sv
// Shared types and helpers for the word collector that feeds adder_tree.
package word_collector_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } collector_state_e;

    // Width of the partial-frame word counter for an N-word frame.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/word_collector.sv
// Gathers N words into one held vector for adder_tree; supports overlap of the
// next frame's first word with consumption and zero-padded flush of a partial frame.
module word_collector
    import word_collector_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int CW    = count_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data [N-1:0],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    collector_state_e state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] slots_q [N-1:0];
    logic [WIDTH-1:0] slots_d [N-1:0];
    logic             accept;

    assign in_ready  = (state_q == COLLECT) || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_data  = slots_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;

    always_comb begin
        // NOTE: every next-state signal takes its current value first, so no
        // path through this block leaves a variable unassigned (no latches).
        state_d     = state_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        slots_d     = slots_q;

        unique case (state_q)
            COLLECT: begin
                if (accept && count_q == LAST_IDX) begin
                    slots_d[count_q] = in_data;
                    count_d          = '0;
                    state_d          = HOLD;
                    out_valid_d      = 1'b1;
                end else if (flush && (accept || count_q != '0)) begin
                    // Pad from the current slot upward, then drop the accepted word in.
                    for (int i = 0; i < N; i++) begin
                        if (CW'(i) >= count_q) slots_d[i] = '0;
                    end
                    if (accept) slots_d[count_q] = in_data;
                    count_d     = '0;
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                end else if (accept) begin
                    slots_d[count_q] = in_data;
                    count_d          = count_q + CW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = COLLECT;
                    out_valid_d = 1'b0;
                    if (accept) begin
                        slots_d[0] = in_data;
                        count_d    = CW'(1);
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            // NOTE: the slot array is reset because its contents are visible on
            // out_data straight after reset; it is a small register bank, not a RAM.
            for (int i = 0; i < N; i++) slots_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            slots_q     <= slots_d;
        end
    end

endmodule

// File: tb/tb_word_collector.sv
// Self-checking bench for word_collector: queue-based frame model checked every
// cycle, plus directed literal expectations from the test plan.
module tb_word_collector;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         flush = 1'b0;
    logic [W-1:0] out_data [N-1:0];
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   count;

    logic [3:0]   in2_data = '0;
    logic         in2_valid = 1'b0;
    logic         in2_ready;
    logic [3:0]   out2_data [1:0];
    logic         out2_valid;
    logic [0:0]   count2;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    word_collector #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .count(count)
    );

    word_collector #(.WIDTH(4), .N(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in2_data), .in_valid(in2_valid),
        .in_ready(in2_ready), .flush(1'b0), .out_data(out2_data),
        .out_valid(out2_valid), .out_ready(1'b0), .count(count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words accepted into the open frame, and the frame being presented.
    logic [W-1:0] m_q [$];
    logic [W-1:0] m_frame [N];
    bit           m_hold;
    bit           m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_hold = 1'b0;
            for (int i = 0; i < N; i++) m_frame[i] = '0;
        end else begin
            m_acc = in_valid && (m_hold ? out_ready : 1'b1);
            if (m_hold) begin
                if (out_ready) begin
                    m_hold = 1'b0;
                    if (m_acc) m_q.push_back(in_data);
                end
            end else begin
                if (m_acc) m_q.push_back(in_data);
                if (m_q.size() == N || (flush && m_q.size() > 0)) begin
                    for (int i = 0; i < N; i++) m_frame[i] = (i < m_q.size()) ? m_q[i] : '0;
                    m_q.delete();
                    m_hold = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("in_ready", in_ready, m_hold ? out_ready : 1'b1);
            check("out_valid", out_valid, m_hold);
            check("count", count, m_q.size());
            if (m_hold) begin
                for (int i = 0; i < N; i++) check($sformatf("slot%0d", i), out_data[i], m_frame[i]);
            end
        end
    end

    function automatic logic [W-1:0] dut_sum();
        logic [W-1:0] s = '0;
        for (int i = 0; i < N; i++) s = s + out_data[i];
        return s;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] d, input logic f, input logic r);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] exp_sums [3];
        exp_sums[0] = 8'd10; exp_sums[1] = 8'd26; exp_sums[2] = 8'd42;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_slot3", out_data[3], 0);

        // Narrow instance: 7 + 9 wraps to 0 in 4 bits.
        in2_valid = 1'b1; in2_data = 4'd7;
        @(posedge clk); #1;
        in2_data = 4'd9;
        @(posedge clk); #1;
        in2_valid = 1'b0;
        check("n2_valid", out2_valid, 1);
        check("n2_slot0", out2_data[0], 7);
        check("n2_slot1", out2_data[1], 9);
        check("n2_sum", 4'(out2_data[0] + out2_data[1]), 0);

        // Basic frame.
        drive(1, 8'd10, 0, 1);
        drive(1, 8'd20, 0, 1);
        drive(1, 8'd30, 0, 1);
        check("pre_valid", out_valid, 0);
        drive(1, 8'd40, 0, 1);
        check("f1_valid", out_valid, 1);
        check("f1_slot0", out_data[0], 10);
        check("f1_slot3", out_data[3], 40);
        check("f1_sum", dut_sum(), 100);

        // Backpressure: held frame stable, offered words refused.
        for (int k = 0; k < 5; k++) begin
            drive(1, 8'd99, 0, 0);
            check("bp_in_ready", in_ready, 0);
            check("bp_slot3", out_data[3], 40);
        end
        drive(0, 0, 0, 1);
        check("bp_count", count, 0);

        // Partial frame flush.
        drive(1, 8'd7, 0, 1);
        drive(1, 8'd9, 0, 1);
        drive(0, 0, 1, 1);
        check("fl_valid", out_valid, 1);
        check("fl_slot0", out_data[0], 7);
        check("fl_slot1", out_data[1], 9);
        check("fl_slot2", out_data[2], 0);
        check("fl_count", count, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 1, 1);
        check("fl_empty_ignored", out_valid, 0);
        drive(1, 8'd5, 1, 1);
        check("fl_acc_slot0", out_data[0], 5);
        check("fl_acc_slot1", out_data[1], 0);
        drive(0, 0, 0, 1);
        drive(1, 8'd50, 0, 1);
        drive(1, 8'd60, 0, 1);
        drive(1, 8'd70, 0, 1);
        drive(1, 8'd80, 1, 1);
        check("fl_full_slot3", out_data[3], 80);
        drive(0, 0, 0, 1);

        // Full-throughput stream of 1..12.
        for (int i = 1; i <= 12; i++) begin
            drive(1, W'(i), 0, 1);
            check("st_in_ready", in_ready, 1);
            if (i % 4 == 0) begin
                check("st_valid", out_valid, 1);
                check("st_sum", dut_sum(), exp_sums[i/4 - 1]);
            end else begin
                check("st_bubble", out_valid, 0);
            end
        end
        drive(0, 0, 0, 1);

        // Reset mid-frame.
        drive(1, 8'd200, 0, 1);
        drive(1, 8'd150, 0, 1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mr_count", count, 0);
        check("mr_out_valid", out_valid, 0);
        check("mr_slot0", out_data[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(1, 8'd255, 0, 1);
        check("wr_valid", out_valid, 1);
        check("wr_slot1", out_data[1], 255);
        check("wr_sum", dut_sum(), 252);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
